out_serial_tx: RTL and testbench

OUT_SERIAL_TX -- requirements
Module: out_serial_tx

---
 rtl/out_serial_tx.sv | 97 +++++++++
 tb/tb_out_serial_tx.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/out_serial_tx.sv
// Byte-wide serial transmitter: one start bit (0), eight data bits LSB first, one stop bit (1).
// Every bit lasts CLKS_PER_BIT clocks; all outputs come straight from flops.
module out_serial_tx #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in,
    input  logic       low_i_en,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    shreg_q;
    logic          tx_q;
    logic          busy_q;
    logic          done_q;
    logic          last_clk;

    assign last_clk = (cnt_q == CNT_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= 8'h00;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    bit_q <= '0;
                    // Accepting on the done cycle gives exactly one idle-high cycle between frames.
                    if (!low_i_en) begin
                        shreg_q <= in;
                        state_q <= START;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (last_clk) begin
                        cnt_q   <= '0;
                        state_q <= DATA;
                        tx_q    <= shreg_q[0];
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DATA: begin
                    if (last_clk) begin
                        cnt_q <= '0;
                        if (bit_q == 3'd7) begin
                            bit_q   <= '0;
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                            tx_q  <= shreg_q[bit_q + 3'd1];
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                STOP: begin
                    if (last_clk) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_out_serial_tx.sv
// Directed bench for out_serial_tx at CLKS_PER_BIT=4 (dut4) and CLKS_PER_BIT=1 (dut1).
// Inputs change and outputs are sampled on the falling edge.
module tb_out_serial_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in4, in1;
    logic       len4, len1;
    logic       tx4, busy4, done4;
    logic       tx1, busy1, done1;

    int ncmp = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    out_serial_tx #(.CLKS_PER_BIT(4)) dut4 (
        .clk(clk), .reset(reset), .in(in4), .low_i_en(len4),
        .tx(tx4), .busy(busy4), .done(done4)
    );

    out_serial_tx #(.CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .reset(reset), .in(in1), .low_i_en(len1),
        .tx(tx1), .busy(busy1), .done(done1)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Expected line level in cycle i (0 = first START cycle) of a 4-clock-per-bit frame.
    function automatic logic exp_tx4(input logic [7:0] d, input int i);
        int slot;
        slot = i / 4;
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return d[slot-1];
    endfunction

    task automatic load4(input logic [7:0] d);
        in4  = d;
        len4 = 1'b0;
        tick();
        len4 = 1'b1;
        in4  = 8'hxx;
    endtask

    // Checks the 40 frame cycles; optionally pulses a load with 8'hFF at cycle glitch_at.
    // Returns sitting in the done cycle.
    task automatic body4(input string tag, input logic [7:0] d, input int glitch_at);
        for (int i = 0; i < 40; i++) begin
            chk({tag, "_tx"}, {7'd0, tx4}, {7'd0, exp_tx4(d, i)});
            chk({tag, "_busy"}, {7'd0, busy4}, 8'd1);
            chk({tag, "_done"}, {7'd0, done4}, 8'd0);
            if (i == glitch_at) begin
                len4 = 1'b0;
                in4  = 8'hFF;
            end else begin
                len4 = 1'b1;
            end
            tick();
        end
        len4 = 1'b1;
        chk({tag, "_done_pulse"}, {7'd0, done4}, 8'd1);
        chk({tag, "_done_busy"}, {7'd0, busy4}, 8'd0);
        chk({tag, "_done_tx"}, {7'd0, tx4}, 8'd1);
    endtask

    task automatic idle4(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk({tag, "_idle_tx"}, {7'd0, tx4}, 8'd1);
            chk({tag, "_idle_busy"}, {7'd0, busy4}, 8'd0);
            chk({tag, "_idle_done"}, {7'd0, done4}, 8'd0);
        end
    endtask

    logic [9:0] seq1;

    initial begin
        reset = 1'b1;
        len4  = 1'b1;
        len1  = 1'b1;
        in4   = 8'h00;
        in1   = 8'h00;
        @(negedge clk);
        tick();
        chk("rst_tx", {7'd0, tx4}, 8'd1);
        chk("rst_busy", {7'd0, busy4}, 8'd0);
        chk("rst_done", {7'd0, done4}, 8'd0);
        chk("rst_tx1", {7'd0, tx1}, 8'd1);

        // Reset beats a simultaneous load.
        in4  = 8'h12;
        len4 = 1'b0;
        tick();
        chk("rstload_tx", {7'd0, tx4}, 8'd1);
        chk("rstload_busy", {7'd0, busy4}, 8'd0);
        reset = 1'b0;
        len4  = 1'b1;
        idle4("rstload", 3);

        // Basic frame 8'hA5; first load after reset accepted.
        load4(8'hA5);
        body4("a5", 8'hA5, -1);
        idle4("a5", 2);

        // Load attempt mid-frame must be ignored.
        load4(8'h3C);
        body4("3c", 8'h3C, 10);
        idle4("3c", 3);

        // Back-to-back: load during done cycle.
        load4(8'h00);
        body4("b2b0", 8'h00, -1);
        in4  = 8'h81;
        len4 = 1'b0;
        tick();
        len4 = 1'b1;
        body4("b2b81", 8'h81, -1);
        idle4("b2b", 2);

        // Abort with reset at cycle 17.
        load4(8'hFF);
        for (int i = 0; i < 17; i++) begin
            chk("abort_tx", {7'd0, tx4}, {7'd0, exp_tx4(8'hFF, i)});
            chk("abort_busy", {7'd0, busy4}, 8'd1);
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_tx_now", {7'd0, tx4}, 8'd1);
        chk("abort_busy_now", {7'd0, busy4}, 8'd0);
        idle4("abort", 45);
        load4(8'h55);
        body4("55", 8'h55, -1);
        idle4("55", 2);

        // CLKS_PER_BIT=1, in=8'h01.
        seq1 = 10'b1000000010;
        in1  = 8'h01;
        len1 = 1'b0;
        tick();
        len1 = 1'b1;
        in1  = 8'hxx;
        for (int i = 0; i < 10; i++) begin
            chk("c1_tx", {7'd0, tx1}, {7'd0, seq1[i]});
            chk("c1_busy", {7'd0, busy1}, 8'd1);
            chk("c1_done", {7'd0, done1}, 8'd0);
            tick();
        end
        chk("c1_done_pulse", {7'd0, done1}, 8'd1);
        chk("c1_done_tx", {7'd0, tx1}, 8'd1);
        tick();
        chk("c1_after_done", {7'd0, done1}, 8'd0);

        // Held load at CLKS_PER_BIT=1: one frame every 11 cycles.
        in1  = 8'hC3;
        len1 = 1'b0;
        tick();
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 10; i++) begin
                chk("hold_tx", {7'd0, tx1}, {7'd0, (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : in1[i-1]});
                chk("hold_busy", {7'd0, busy1}, 8'd1);
                tick();
            end
            chk("hold_done", {7'd0, done1}, 8'd1);
            chk("hold_gap_tx", {7'd0, tx1}, 8'd1);
            tick();
        end
        len1 = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
